enthdr_target_detect: RTL

- Target-side counterpart of the controller ENTHDR sequencer.
- Monitors SDR bus traffic for a broadcast address (7'h7E, W), drives the open-drain ACK, then receives the CCC byte and its T bit.
- Enters HDR-DDR mode when the byte is ENTHDR0 and parity is correct.
- Sits between the target bus-condition detector (START/Sr/STOP, SCL edges) and the target HDR engine.

---
 rtl/enthdr_target_detect.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/enthdr_target_detect.sv
// ---------------------------------------------------------------------------
// enthdr_target_detect
//
// Target-side ENTHDR detector. Watches SDR traffic for the broadcast address
// (BCAST_ADDR, write), ACKs it by pulling SDA low, then receives the CCC
// byte plus its T (odd parity) bit. When the CCC is ENTHDR_CODE with correct
// parity the target enters HDR-DDR mode until the HDR engine reports exit.
//
// Ports:
//   i_clk           system clock
//   i_rst           synchronous, active-high reset
//   i_en            block enable; 0 holds the FSM in IDLE (ignored in HDR)
//   i_scl_pos_edge  one-cycle pulse on SCL rising edge (bit sample point)
//   i_scl_neg_edge  one-cycle pulse on SCL falling edge
//   i_sda           synchronized SDA level
//   i_start_det     pulse on START / repeated START
//   i_stop_det      pulse on STOP
//   i_hdr_exit      pulse from the HDR engine on the HDR exit pattern
//   o_sda_low       1 = pull SDA low (open drain), only during the ACK bit
//   o_ccc_valid     one-cycle pulse: CCC byte and T bit received
//   o_ccc_code      last received CCC byte, held until the next o_ccc_valid
//   o_parity_err    one-cycle pulse with o_ccc_valid on T-bit mismatch
//   o_hdr_ddr_en    level: target is in HDR-DDR mode
//   o_busy          1 whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module enthdr_target_detect #(
    parameter logic [6:0] BCAST_ADDR  = 7'h7E,
    parameter logic [7:0] ENTHDR_CODE = 8'h20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_scl_pos_edge,
    input  logic       i_scl_neg_edge,
    input  logic       i_sda,
    input  logic       i_start_det,
    input  logic       i_stop_det,
    input  logic       i_hdr_exit,
    output logic       o_sda_low,
    output logic       o_ccc_valid,
    output logic [7:0] o_ccc_code,
    output logic       o_parity_err,
    output logic       o_hdr_ddr_en,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK,
        ST_CCC,
        ST_CHECK,
        ST_IGNORE,
        ST_HDR
    } state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    // Holds {addr[6:0], RnW} in [7:0] during ADDR and {D7..D0, T} during CCC.
    logic [8:0] shreg;
    logic       parity_ok;
    logic       in_frame;

    // T is odd parity over the data byte.
    always_comb begin
        parity_ok = (shreg[0] == ~(^shreg[8:1]));
    end

    always_comb begin
        in_frame = (state == ST_ADDR) || (state == ST_ACK) || (state == ST_CCC);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            o_sda_low    <= 1'b0;
            o_ccc_valid  <= 1'b0;
            o_ccc_code   <= '0;
            o_parity_err <= 1'b0;
            o_hdr_ddr_en <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            // Pulses default low; o_sda_low is re-asserted only while
            // entering or remaining in ACK, so every exit path releases SDA.
            o_ccc_valid  <= 1'b0;
            o_parity_err <= 1'b0;
            o_sda_low    <= 1'b0;

            if (!i_en && (state != ST_HDR)) begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
            end else if (in_frame && i_stop_det) begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
            end else if (in_frame && i_start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                o_busy  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start_det) begin
                            state   <= ST_ADDR;
                            bit_cnt <= '0;
                            o_busy  <= 1'b1;
                        end
                    end

                    ST_ADDR: begin
                        if (i_scl_pos_edge && (bit_cnt != 4'd8)) begin
                            shreg   <= {shreg[7:0], i_sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (i_scl_neg_edge && (bit_cnt == 4'd8)) begin
                            if (shreg[7:0] == {BCAST_ADDR, 1'b0}) begin
                                state     <= ST_ACK;
                                o_sda_low <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end

                    ST_ACK: begin
                        if (i_scl_neg_edge) begin
                            state   <= ST_CCC;
                            bit_cnt <= '0;
                        end else begin
                            o_sda_low <= 1'b1;
                        end
                    end

                    ST_CCC: begin
                        if (i_scl_pos_edge) begin
                            shreg <= {shreg[7:0], i_sda};
                            if (bit_cnt == 4'd8) begin
                                state <= ST_CHECK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_CHECK: begin
                        o_ccc_valid  <= 1'b1;
                        o_ccc_code   <= shreg[8:1];
                        o_parity_err <= ~parity_ok;
                        if ((shreg[8:1] == ENTHDR_CODE) && parity_ok) begin
                            state        <= ST_HDR;
                            o_hdr_ddr_en <= 1'b1;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end

                    ST_IGNORE: begin
                        if (i_stop_det) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end else if (i_start_det) begin
                            state   <= ST_ADDR;
                            bit_cnt <= '0;
                        end
                    end

                    ST_HDR: begin
                        // SDR START/STOP and i_en are ignored while in HDR.
                        if (i_hdr_exit) begin
                            state        <= ST_IDLE;
                            o_hdr_ddr_en <= 1'b0;
                            o_busy       <= 1'b0;
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
